// File: rtl/bf_loop_ctrl.sv
// TinyBF loop-control unit: return-address stack for taken loops and
// a nesting counter for forward-skipping loops entered on a zero cell.
module bf_loop_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 8,
  parameter int SKIP_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      op_valid,
  input  logic                      op_open,
  input  logic                      op_close,
  input  logic [ADDR_W-1:0]         pc,
  input  logic                      cell_zero,
  input  logic                      err_clear,
  output logic                      jump_valid,
  output logic [ADDR_W-1:0]         jump_addr,
  output logic                      skip_active,
  output logic [$clog2(DEPTH):0]    depth,
  output logic                      full,
  output logic                      empty,
  output logic                      err_overflow,
  output logic                      err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  localparam logic [SKIP_W-1:0] SKIP_MAX = {SKIP_W{1'b1}};
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);

  logic [ADDR_W-1:0] stack_q [DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              jv_q, jv_d;
  logic [ADDR_W-1:0] ja_q, ja_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push, ev_ovf, ev_unf;

  logic              is_open, is_close, in_skip;
  logic              st_full, st_empty;
  logic [AW-1:0]     top_idx, wr_idx;
  logic [ADDR_W-1:0] top_addr;

  assign is_open  = op_valid & op_open & ~op_close;
  assign is_close = op_valid & op_close & ~op_open;
  assign in_skip  = skip_q != '0;
  assign st_full  = depth_q == DEPTH_V;
  assign st_empty = depth_q == '0;
  assign wr_idx   = depth_q[AW-1:0];
  // At full occupancy the low bits wrap to 0, so minus one still
  // addresses the last slot.
  assign top_idx  = depth_q[AW-1:0] - AW'(1);
  assign top_addr = stack_q[top_idx];

  always_comb begin
    depth_d = depth_q;
    skip_d  = skip_q;
    jv_d    = 1'b0;
    ja_d    = ja_q;
    push    = 1'b0;
    ev_ovf  = 1'b0;
    ev_unf  = 1'b0;
    unique case (1'b1)
      in_skip & is_open: begin
        if (skip_q == SKIP_MAX) ev_ovf = 1'b1;
        else skip_d = skip_q + SKIP_W'(1);
      end
      in_skip & is_close: begin
        skip_d = skip_q - SKIP_W'(1);
      end
      ~in_skip & is_open & cell_zero: begin
        skip_d = SKIP_W'(1);
      end
      ~in_skip & is_open & ~cell_zero: begin
        if (st_full) begin
          ev_ovf = 1'b1;
        end else begin
          push    = 1'b1;
          depth_d = depth_q + DW'(1);
        end
      end
      ~in_skip & is_close & st_empty: begin
        ev_unf = 1'b1;
      end
      ~in_skip & is_close & ~st_empty & cell_zero: begin
        depth_d = depth_q - DW'(1);
      end
      ~in_skip & is_close & ~st_empty & ~cell_zero: begin
        jv_d = 1'b1;
        ja_d = top_addr;
      end
      default: ;
    endcase
    // A new error event wins over a same-cycle clear.
    ovf_d = (ovf_q & ~err_clear) | ev_ovf;
    unf_d = (unf_q & ~err_clear) | ev_unf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
      skip_q  <= '0;
      jv_q    <= 1'b0;
      ja_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (flush) begin
      depth_q <= '0;
      skip_q  <= '0;
      jv_q    <= 1'b0;
      ja_q    <= '0;
    end else begin
      depth_q <= depth_d;
      skip_q  <= skip_d;
      jv_q    <= jv_d;
      ja_q    <= ja_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      stack_q[wr_idx] <= pc + ADDR_W'(1);
    end
  end

  assign jump_valid    = jv_q;
  assign jump_addr     = ja_q;
  assign skip_active   = in_skip;
  assign depth         = depth_q;
  assign full          = st_full;
  assign empty         = st_empty;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Bench for bf_loop_ctrl: directed scenarios plus a randomized run
// checked against a queue-based bracket-matching reference model.
module tb_bf_loop_ctrl;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 8;
  localparam int SKIP_W = 4;
  localparam int SKIP_MAX = (1 << SKIP_W) - 1;

  logic clk = 1'b0;
  logic rst, flush, op_valid, op_open, op_close, cell_zero, err_clear;
  logic [ADDR_W-1:0] pc;
  logic jump_valid, skip_active, full, empty;
  logic err_overflow, err_underflow;
  logic [ADDR_W-1:0] jump_addr;
  logic [3:0] depth;

  int n_pass = 0;
  int n_chk  = 0;

  int m_stk[$];
  int m_skip;
  bit m_ovf, m_unf, m_jv;
  int m_ja;

  bf_loop_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SKIP_W(SKIP_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_open(op_open), .op_close(op_close),
    .pc(pc), .cell_zero(cell_zero), .err_clear(err_clear),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .skip_active(skip_active), .depth(depth),
    .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit fl, input bit v,
                      input bit o, input bit c, input int p,
                      input bit cz, input bit clr);
    bit eo, eu;
    rst = r; flush = fl; op_valid = v; op_open = o;
    op_close = c; pc = p[ADDR_W-1:0]; cell_zero = cz; err_clear = clr;
    eo = 0; eu = 0;
    if (r) begin
      m_stk.delete(); m_skip = 0; m_jv = 0; m_ja = 0;
      m_ovf = 0; m_unf = 0;
    end else if (fl) begin
      m_stk.delete(); m_skip = 0; m_jv = 0; m_ja = 0;
    end else begin
      m_jv = 0;
      if (v && (o != c)) begin
        if (m_skip > 0) begin
          if (o) begin
            if (m_skip == SKIP_MAX) eo = 1;
            else m_skip++;
          end else m_skip--;
        end else if (o) begin
          if (cz) m_skip = 1;
          else if (m_stk.size() == DEPTH) eo = 1;
          else m_stk.push_back((p + 1) % (1 << ADDR_W));
        end else begin
          if (m_stk.size() == 0) eu = 1;
          else if (cz) void'(m_stk.pop_back());
          else begin m_jv = 1; m_ja = m_stk[$]; end
        end
      end
      if (clr) begin m_ovf = 0; m_unf = 0; end
      if (eo) m_ovf = 1;
      if (eu) m_unf = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic opn(input int p, input bit cz);
    step(0, 0, 1, 1, 0, p, cz, 0);
  endtask

  task automatic cls(input int p, input bit cz);
    step(0, 0, 1, 0, 1, p, cz, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [15:0] obs, exp_v;
    step(1, 0, 1, 1, 0, 9, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) idle();
    obs = {depth, empty, full, skip_active, jump_valid, jump_addr,
           err_overflow, err_underflow};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp_v) $display("FAIL reset_state got %h want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_basic_loop();
    opn(3, 0);
    n_chk++;
    if (depth !== 4'd1) $display("FAIL basic_push depth got %0d want 1", depth);
    else n_pass++;
    cls(7, 0);
    n_chk++;
    if ({jump_valid, jump_addr, depth} !== {1'b1, 5'd4, 4'd1})
      $display("FAIL basic_jump jv=%b ja=%0d depth=%0d want 1/4/1",
               jump_valid, jump_addr, depth);
    else n_pass++;
    cls(7, 1);
    n_chk++;
    if ({jump_valid, depth, empty} !== {1'b0, 4'd0, 1'b1})
      $display("FAIL basic_exit jv=%b depth=%0d empty=%b want 0/0/1",
               jump_valid, depth, empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    opn(10, 0);
    cls(11, 0);
    n_chk++;
    if ({jump_valid, jump_addr} !== {1'b1, 5'd11})
      $display("FAIL b2b_jump jv=%b ja=%0d want 1/11", jump_valid, jump_addr);
    else n_pass++;
    opn(31, 0);
    cls(12, 0);
    n_chk++;
    if ({jump_valid, jump_addr, depth} !== {1'b1, 5'd0, 4'd2})
      $display("FAIL b2b_wrap jv=%b ja=%0d depth=%0d want 1/0/2",
               jump_valid, jump_addr, depth);
    else n_pass++;
    idle();
    n_chk++;
    if (jump_valid !== 1'b0) $display("FAIL b2b_pulse jv got %b want 0", jump_valid);
    else n_pass++;
    cls(13, 1);
    cls(14, 1);
    n_chk++;
    if (empty !== 1'b1) $display("FAIL b2b_drain empty got %b want 1", empty);
    else n_pass++;
  endtask

  task automatic test_skip_nesting();
    bit exp_sa [4] = '{1, 1, 1, 0};
    bit jv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      bit cz = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i < 2) opn(i + 1, cz);
      else cls(i + 1, cz);
      if (jump_valid) jv_seen = 1;
      n_chk++;
      if (skip_active !== exp_sa[i] || depth !== 4'd0)
        $display("FAIL skip_nest op%0d sa=%b depth=%0d want %b/0",
                 i, skip_active, depth, exp_sa[i]);
      else n_pass++;
    end
    n_chk++;
    if (jv_seen) $display("FAIL skip_nojump saw jump_valid want none");
    else n_pass++;
    opn(5, 0);
    opn(6, 1);
    cls(7, $urandom_range(0, 1));
    n_chk++;
    if ({skip_active, depth, jump_valid} !== {1'b0, 4'd1, 1'b0})
      $display("FAIL skip_keep sa=%b depth=%0d jv=%b want 0/1/0",
               skip_active, depth, jump_valid);
    else n_pass++;
    cls(8, 1);
  endtask

  task automatic test_skip_saturate();
    opn(0, 1);
    for (int i = 0; i < SKIP_MAX - 1; i++) opn(1, $urandom_range(0, 1));
    n_chk++;
    if (err_overflow !== 1'b0) $display("FAIL sat_pre ovf got %b want 0", err_overflow);
    else n_pass++;
    opn(2, 0);
    n_chk++;
    if ({err_overflow, skip_active} !== 2'b11)
      $display("FAIL sat_ovf ovf=%b sa=%b want 1/1", err_overflow, skip_active);
    else n_pass++;
    for (int i = 0; i < SKIP_MAX - 1; i++) cls(3, $urandom_range(0, 1));
    n_chk++;
    if (skip_active !== 1'b1) $display("FAIL sat_hold sa got %b want 1", skip_active);
    else n_pass++;
    cls(4, 0);
    n_chk++;
    if ({skip_active, jump_valid, depth} !== {1'b0, 1'b0, 4'd0})
      $display("FAIL sat_exit sa=%b jv=%b depth=%0d want 0/0/0",
               skip_active, jump_valid, depth);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) opn(i, 0);
    n_chk++;
    if ({full, depth, err_overflow} !== {1'b1, 4'd8, 1'b0})
      $display("FAIL ovf_full full=%b depth=%0d ovf=%b want 1/8/0",
               full, depth, err_overflow);
    else n_pass++;
    opn(20, 0);
    n_chk++;
    if ({err_overflow, depth} !== {1'b1, 4'd8})
      $display("FAIL ovf_set ovf=%b depth=%0d want 1/8", err_overflow, depth);
    else n_pass++;
    cls(21, 0);
    n_chk++;
    if ({jump_valid, jump_addr} !== {1'b1, 5'd8})
      $display("FAIL ovf_top jv=%b ja=%0d want 1/8", jump_valid, jump_addr);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) cls(22, 1);
    n_chk++;
    if ({empty, err_overflow} !== 2'b11)
      $display("FAIL ovf_sticky empty=%b ovf=%b want 1/1", empty, err_overflow);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (err_overflow !== 1'b0) $display("FAIL ovf_clear ovf got %b want 0", err_overflow);
    else n_pass++;
  endtask

  task automatic test_underflow();
    step(0, 0, 1, 1, 1, 4, 0, 0);
    n_chk++;
    if ({err_underflow, err_overflow, depth, skip_active} !== {2'b00, 4'd0, 1'b0})
      $display("FAIL both_noop unf=%b ovf=%b depth=%0d sa=%b want 0/0/0/0",
               err_underflow, err_overflow, depth, skip_active);
    else n_pass++;
    cls(5, 0);
    n_chk++;
    if ({err_underflow, jump_valid} !== 2'b10)
      $display("FAIL unf_set unf=%b jv=%b want 1/0", err_underflow, jump_valid);
    else n_pass++;
    step(0, 0, 1, 0, 1, 6, 1, 1);
    n_chk++;
    if (err_underflow !== 1'b1) $display("FAIL unf_prio unf got %b want 1", err_underflow);
    else n_pass++;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    n_chk++;
    if (err_underflow !== 1'b0) $display("FAIL unf_clear unf got %b want 0", err_underflow);
    else n_pass++;
  endtask

  task automatic test_interrupts();
    logic [15:0] obs, exp_v;
    cls(1, 0);
    opn(2, 0);
    opn(3, 0);
    opn(4, 1);
    n_chk++;
    if ({depth, skip_active} !== {4'd2, 1'b1})
      $display("FAIL intr_setup depth=%0d sa=%b want 2/1", depth, skip_active);
    else n_pass++;
    step(0, 1, 1, 1, 0, 5, 0, 0);
    n_chk++;
    if ({depth, skip_active, jump_valid, err_underflow, err_overflow}
        !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL intr_flush depth=%0d sa=%b jv=%b unf=%b ovf=%b want 0/0/0/1/0",
               depth, skip_active, jump_valid, err_underflow, err_overflow);
    else n_pass++;
    opn(6, 0);
    opn(7, 0);
    opn(8, 1);
    step(1, 0, 1, 0, 1, 9, 0, 0);
    obs = {depth, empty, full, skip_active, jump_valid, jump_addr,
           err_overflow, err_underflow};
    exp_v = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    n_chk++;
    if (obs !== exp_v) $display("FAIL intr_reset got %h want %h", obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      int k = $urandom_range(0, 9);
      bit o = (k < 5);
      bit c = (k >= 4);
      bit cz = o ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) == 0);
      step(0, $urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, o, c,
           $urandom_range(0, 31), cz, $urandom_range(0, 24) == 0);
      n_chk++;
      if (depth !== 4'(m_stk.size()) || skip_active !== (m_skip != 0) ||
          jump_valid !== m_jv || (m_jv && jump_addr !== 5'(m_ja)) ||
          full !== (m_stk.size() == DEPTH) || empty !== (m_stk.size() == 0) ||
          err_overflow !== m_ovf || err_underflow !== m_unf) begin
        if (bad < 10)
          $display("FAIL rand_cyc%0d got d=%0d sa=%b jv=%b ja=%0d f=%b e=%b o=%b u=%b want d=%0d sa=%b jv=%b ja=%0d o=%b u=%b",
                   i, depth, skip_active, jump_valid, jump_addr, full, empty,
                   err_overflow, err_underflow, m_stk.size(), m_skip != 0,
                   m_jv, m_ja, m_ovf, m_unf);
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_back_to_back();
    test_skip_nesting();
    test_skip_saturate();
    test_overflow();
    test_underflow();
    test_interrupts();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_loop_ctrl.md
Name: bf_loop_ctrl

Overview:
Parametrised loop-control unit for the TinyBF Brainfuck CPU family. It resolves '[' and ']' without a precomputed jump table. A return-address stack handles taken loops, and a nesting counter forward-skips loops whose entry cell is zero. It sits beside the program counter in the core's fetch/execute FSM and replaces the fixed-depth bracket logic of the first generation. Configurable depth and widths, sticky error reporting and a flush input are new.

Parameters:
ADDR_W, 5, program-address width (stack entry width)
DEPTH, 8, return-stack entries (power of two, >=2)
SKIP_W, 4, width of forward-skip nesting counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of stack and skip state; error flags kept
op_valid  in  1  current instruction is presented this cycle
op_open  in  1  instruction is '['
op_close  in  1  instruction is ']'
pc  in  ADDR_W  address of the presented instruction
cell_zero  in  1  current tape cell == 0
err_clear  in  1  clears sticky error flags
jump_valid  out  1  one-cycle pulse: load jump_addr into PC
jump_addr  out  ADDR_W  loop-body start address (valid with jump_valid)
skip_active  out  1  core is forward-scanning; suppress all non-bracket side effects
depth  out  $clog2(DEPTH)+1  stack occupancy
full  out  1  depth == DEPTH
empty  out  1  depth == 0
err_overflow  out  1  sticky: push on full stack or skip-counter saturation
err_underflow  out  1  sticky: ']' with empty stack outside skip

Behaviour:
- Reset (rst=1): stack empty, depth=0, empty=1, full=0, skip counter=0, skip_active=0, jump_valid=0, jump_addr=0, both error flags=0. rst has priority over all other inputs.
- flush: same as reset, except err_overflow and err_underflow hold. flush has priority over op_valid.
- An instruction is acted on only when op_valid=1. op_open=op_close=1 together is a no-op with no flag.
- All outputs are registered. State and flag updates become visible the cycle after the op. jump_valid is high for exactly one cycle.
- Normal mode, '[' with cell_zero=0:
  - push pc+1 (mod 2^ADDR_W); depth+1.
  - If full: no push, err_overflow set.
- Normal mode, '[' with cell_zero=1: enter skip mode, skip counter=1, skip_active=1; no push.
- Normal mode, ']' with cell_zero=0: jump_valid=1, jump_addr=top entry; stack unchanged.
- Normal mode, ']' with cell_zero=1: pop, no jump.
- Normal mode, ']' with empty stack: no jump, no pop, err_underflow set.
- Skip mode: cell_zero is ignored and the stack is never touched.
  - '[' increments the skip counter. At 2^SKIP_W-1 it saturates and sets err_overflow.
  - ']' decrements the skip counter. At count 1 it exits skip: counter=0, skip_active=0 next cycle.
  - The matching ']' itself causes no jump and no pop.
- Skip state is orthogonal to the stack: depth is preserved across a skip.
- err_clear: clears both flags. If an error event occurs in the same cycle, set wins.
- Back-to-back ops every cycle are supported. A push followed by a ']' on the next cycle jumps to the just-pushed address (no bubble).

Test Plan:
- Reset, then idle 5 cycles -> depth=0, empty=1, skip_active=0, jump_valid=0, flags=0.
- '[' at pc=3 (cell_zero=0), ']' at pc=7 (cell_zero=0) -> next cycle jump_valid=1, jump_addr=4, depth=1. Then ']' at pc=7 (cell_zero=1) -> no jump, depth=0, empty=1.
- Skip with nesting:
  - Stimulus: '[' with cell_zero=1, then '[', ']', ']' with cell_zero toggling randomly.
  - Required: skip_active high from cycle after the first op until the cycle after the 4th op; depth stays 0; no jump_valid pulse.
- Overflow:
  - Push DEPTH=8 loops -> full=1. A 9th '[' (cell_zero=0) -> err_overflow=1, depth=8.
  - Then 8 ']' with cell_zero=1 -> empty=1; err_overflow stays 1 until err_clear.
- Underflow and error priority:
  - ']' on empty stack -> err_underflow=1, no jump.
  - err_clear together with another empty ']' -> err_underflow remains 1.
  - err_clear alone -> 0.
- Mid-operation interrupts:
  - Two pushes plus active skip, then flush -> depth=0, skip_active=0, error flags unchanged.
  - Repeat with rst -> all outputs at reset values next cycle.
